// File: rtl/bitwise_logic_unit.sv
// Bitwise op unit with optional multi-beat fold and zero/all-ones flags; result registered 1 cycle after closing beat.
// Backpressure: in_ready = !out_valid || out_ready, so a held result stalls input; drain and new beat may share a cycle.
module bitwise_logic_unit #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d;
  logic [2:0]       op_q, op_d;
  logic             zero_q, zero_d, ones_q, ones_d;
  logic             accept, closes;
  logic [2:0]       eff_op;
  logic [WIDTH-1:0] r, folded;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    apply_op = a & b;
      3'd1:    apply_op = a | b;
      3'd2:    apply_op = a ^ b;
      3'd3:    apply_op = ~(a & b);
      3'd4:    apply_op = ~(a | b);
      3'd5:    apply_op = ~(a ^ b);
      3'd6:    apply_op = a & ~b;
      default: apply_op = a;
    endcase
  endfunction

  // Inverted ops fold with their base operator; PASSA keeps the latest beat.
  function automatic logic [WIDTH-1:0] fold_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] rv);
    case (op)
      3'd0, 3'd3, 3'd6: fold_op = acc & rv;
      3'd1, 3'd4:       fold_op = acc | rv;
      3'd2, 3'd5:       fold_op = acc ^ rv;
      default:          fold_op = rv;
    endcase
  endfunction

  assign in_ready  = (state_q != OUT) || out_ready;
  assign accept    = in_valid && in_ready;
  assign closes    = in_last || !in_acc;
  assign eff_op    = (state_q == ACCUM) ? op_q : in_op;
  assign r         = apply_op(eff_op, in_a, in_b);
  assign folded    = fold_op(op_q, acc_q, r);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  assign out_valid = (state_q == OUT);
  assign out_data  = data_q;
  assign out_zero  = zero_q;
  assign out_ones  = ones_q;
  assign out_count = ocnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    ocnt_d  = ocnt_q;
    zero_d  = zero_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE, OUT: begin
        if (state_q == OUT && out_ready) state_d = IDLE;
        if (accept) begin
          if (closes) begin
            data_d  = r;
            ocnt_d  = CNT_W'(1);
            zero_d  = (r == '0);
            ones_d  = (r == '1);
            state_d = OUT;
          end else begin
            acc_d   = r;
            cnt_d   = CNT_W'(1);
            op_d    = in_op;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (closes) begin
            data_d  = folded;
            ocnt_d  = cnt_inc;
            zero_d  = (folded == '0);
            ones_d  = (folded == '1);
            state_d = OUT;
          end else begin
            acc_d = folded;
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      ocnt_q  <= '0;
      zero_q  <= 1'b0;
      ones_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      ocnt_q  <= ocnt_d;
      zero_q  <= zero_d;
      ones_q  <= ones_d;
    end
  end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed bench: stimulus pushes expected results into a queue, a monitor pops on each output handshake.
module tb_bitwise_logic_unit;

  localparam int WIDTH = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, in_acc, in_last;
  logic [WIDTH-1:0] in_a, in_b;
  logic [2:0]       in_op;
  logic             out_valid, out_ready, out_zero, out_ones;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             z;
    logic             o;
    logic [CNT_W-1:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  bitwise_logic_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_ones(out_ones),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] c);
    mk = '{d: d, z: (d == '0), o: (d == '1), c: c};
  endfunction

  // Drive one beat starting at posedge+1; returns at posedge+1 after it is accepted.
  task automatic beat(input logic [2:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic acc, input logic last);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_acc = acc; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      failures++;
      $display("FAIL beat_accept_timeout: in_ready stayed 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 3'bx; in_a = 'x; in_b = 'x;
  endtask

  // Monitor: compare every output handshake against the queue head.
  initial begin
    exp_t act, e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        act = '{d: out_data, z: out_zero, o: out_ones, c: out_count};
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result: got %0h expected none", act);
        end else begin
          e = exp_q.pop_front();
          chk("result{data,zero,ones,count}", 32'(act), 32'(e));
        end
      end
    end
  end

  initial begin
    logic [2:0]       sweep_op [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [WIDTH-1:0] sweep_r  [7] = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10};

    reset = 1'b1; in_valid = 1'b0; in_acc = 1'b0; in_last = 1'b0;
    in_a = 'x; in_b = 'x; in_op = 3'bx; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data",  32'(out_data), 0);
    chk("reset_out_zero",  32'(out_zero), 0);
    chk("reset_out_ones",  32'(out_ones), 0);
    chk("reset_out_count", 32'(out_count), 0);
    chk("reset_in_ready",  32'(in_ready), 1);

    // Single AND beat, then op sweep back-to-back.
    exp_q.push_back(mk(2'b01, 2'd1));
    beat(3'd0, 2'b11, 2'b01, 1'b0, 1'b0);
    chk("latency_out_valid", 32'(out_valid), 1);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(mk(sweep_r[i], 2'd1));
      beat(sweep_op[i], 2'b10, 2'b11, 1'b0, 1'b0);
    end

    // XOR fold; in_op on later beats must be ignored.
    beat(3'd2, 2'b01, 2'b00, 1'b1, 1'b0);
    beat(3'd0, 2'b10, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    chk("accum_no_early_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    exp_q.push_back(mk(2'b00, 2'd3));
    beat(3'd7, 2'b11, 2'b00, 1'b1, 1'b1);

    // Backpressure: result held stable, then drain + new beat in one cycle.
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_q.push_back(mk(2'b01, 2'd1));
    beat(3'd0, 2'b11, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready",  32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_hold", 32'({out_data, out_zero, out_ones, out_count}), 32'({2'b01, 1'b0, 1'b0, 2'd1}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back(mk(2'b10, 2'd1));
    beat(3'd1, 2'b00, 2'b10, 1'b0, 1'b0);
    chk("bp_new_result_valid", 32'(out_valid), 1);
    chk("bp_new_result_data",  32'(out_data), 32'(2'b10));

    // Count saturation with AND fold over five beats.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) beat(3'd0, 2'b11, 2'b11, 1'b1, 1'b0);
    exp_q.push_back(mk(2'b11, 2'd3));
    beat(3'd0, 2'b11, 2'b11, 1'b1, 1'b1);

    // Reset mid-packet discards partial state.
    @(posedge clk); #1;
    beat(3'd1, 2'b11, 2'b00, 1'b1, 1'b0);
    beat(3'd1, 2'b10, 2'b00, 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_out_valid", 32'(out_valid), 0);
    chk("midreset_fields", 32'({out_data, out_zero, out_ones, out_count}), 0);
    chk("midreset_in_ready", 32'(in_ready), 1);
    exp_q.push_back(mk(2'b01, 2'd1));
    beat(3'd1, 2'b00, 2'b01, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
